// File: rtl/vram_pkg.sv
// Shared defaults and CPU access state encoding for the video RAM arbiter.
package vram_pkg;
  localparam int VRAM_ADDR_W       = 18;
  localparam int VRAM_DATA_W       = 8;
  localparam int VRAM_STARVE_LIMIT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    DONE   = 2'd2
  } cpu_state_t;
endpackage

// File: rtl/vram_starve_guard.sv
// Counts IDLE cycles where video denies a pending CPU request; forces a CPU grant once the limit is hit.
// Force output is combinational in the decision cycle; the counter clears on any CPU grant.
module vram_starve_guard import vram_pkg::*; #(
  parameter int STARVE_LIMIT = VRAM_STARVE_LIMIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_contend,
  input  logic i_cpu_grant,
  output logic o_force
);
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == CNT_W'(STARVE_LIMIT));
  assign o_force    = i_contend && w_at_limit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_cpu_grant) begin
      r_cnt <= '0;
    end else if (i_contend && !w_at_limit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: scanout reads win with fixed 2-cycle latency, CPU accesses fill idle slots (ack 2 cycles after grant).
// Define VRAM_STARVE_GUARD_EN to force a CPU grant after STARVE_LIMIT denials, dropping that video request.
module vram_arbiter import vram_pkg::*; #(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int STARVE_LIMIT = VRAM_STARVE_LIMIT
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_address,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  cpu_state_t        r_state;
  cpu_state_t        w_state_nxt;
  logic              r_cpu_we;
  logic              r_vid_pend;
  logic [DATA_W-1:0] r_vid_data;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_address;
  logic              r_mem_we;
  logic              w_force_cpu;
  logic              w_cpu_grant;
  logic              w_vid_grant;

  assign w_cpu_grant = (r_state == IDLE) && cpu_req && (!vid_req || w_force_cpu);
  assign w_vid_grant = vid_req && !w_cpu_grant;

`ifdef VRAM_STARVE_GUARD_EN
  logic w_contend;
  logic r_miss_d1;
  logic r_vid_miss;

  assign w_contend = (r_state == IDLE) && cpu_req && vid_req;

  vram_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_guard (
    .i_clk       (clock_50),
    .i_rst       (reset),
    .i_contend   (w_contend),
    .i_cpu_grant (w_cpu_grant),
    .o_force     (w_force_cpu)
  );

  // Miss is aligned with the cycle the dropped read's data would have appeared.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_miss_d1  <= 1'b0;
      r_vid_miss <= 1'b0;
    end else begin
      r_miss_d1  <= vid_req && w_cpu_grant;
      r_vid_miss <= r_miss_d1;
    end
  end

  assign vid_miss = r_vid_miss;
`else
  // Strict video priority: the limit has no meaning here, so a force never fires.
  assign w_force_cpu = (STARVE_LIMIT < 0);
  assign vid_miss    = 1'b0;
`endif

  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_cpu_grant) w_state_nxt = ISSUED;
      ISSUED:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_we      <= 1'b0;
      r_cpu_we      <= 1'b0;
      r_vid_pend    <= 1'b0;
      r_vid_data    <= '0;
      r_cpu_rdata   <= '0;
    end else begin
      if (w_cpu_grant) begin
        r_mem_address <= cpu_address;
        r_mem_wdata   <= cpu_wdata;
        r_mem_we      <= cpu_we;
        r_cpu_we      <= cpu_we;
      end else if (w_vid_grant) begin
        r_mem_address <= vid_address;
        r_mem_we      <= 1'b0;
      end else begin
        r_mem_we      <= 1'b0;
      end
      r_vid_pend <= w_vid_grant;
      if (r_vid_pend) begin
        r_vid_data <= mem_rdata;
      end
      // The bus carries the CPU address during ISSUED, so read data lands here.
      if ((r_state == ISSUED) && !r_cpu_we) begin
        r_cpu_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_ack     = (r_state == DONE);
  assign cpu_rdata   = r_cpu_rdata;
  assign vid_data    = r_vid_data;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we;
endmodule
